// File: rtl/cla_serial_add_ctrl_if.sv
// Operand/result bundle for the serial CLA add/subtract sequencer.
// master drives operands and out_ready; slave is the sequencer side.
interface cla_serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, op_sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, op_sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/cla_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per clock on a single 4-bit
// carry look-ahead slice, LSB nibble first, carry chained through r_carry.
module cla_serial_add_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst,
   cla_serial_add_ctrl_if.slave  io_bus
);
   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_a, r_b, r_sum;
   logic             r_carry, r_cout, r_ovf;
   logic [CntW-1:0]  r_cnt;

   logic             w_accept, w_last;
   logic [3:0]       w_na, w_nb, w_ns, w_g, w_p;
   logic [4:0]       w_c;

   // adder4: single shared carry look-ahead slice, carry-in from r_carry
   always_comb begin
      w_na   = r_a[{r_cnt, 2'b00} +: 4];
      w_nb   = r_b[{r_cnt, 2'b00} +: 4];
      w_g    = w_na & w_nb;
      w_p    = w_na ^ w_nb;
      w_c[0] = r_carry;
      w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
      w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
      w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
             | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
             | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
      w_ns   = w_p ^ w_c[3:0];
   end

   always_comb begin
      w_state_d = r_state;
      w_accept  = 1'b0;
      w_last    = (r_cnt == CntW'(NIB - 1));
      unique case (r_state)
         StIdle: begin
            if (io_bus.in_valid) begin
               w_accept  = 1'b1;
               w_state_d = StRun;
            end
         end
         StRun: begin
            if (w_last) w_state_d = StDone;
         end
         StDone: begin
            if (io_bus.out_ready) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         if (w_accept) begin
            // Subtract is A + ~B + 1; cin is ignored in that mode
            r_a     <= io_bus.a;
            r_b     <= io_bus.b ^ {WIDTH{io_bus.op_sub}};
            r_carry <= io_bus.op_sub | io_bus.cin;
            r_cnt   <= '0;
         end
         if (r_state == StRun) begin
            r_sum[{r_cnt, 2'b00} +: 4] <= w_ns;
            r_carry                    <= w_c[4];
            r_cnt                      <= r_cnt + CntW'(1);
            if (w_last) begin
               r_cout <= w_c[4];
               r_ovf  <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_ns[3] ^ w_c[4];
            end
         end
      end
   end

   assign io_bus.in_ready  = (r_state == StIdle);
   assign io_bus.out_valid = (r_state == StDone);
   assign io_bus.sum       = r_sum;
   assign io_bus.cout      = r_cout;
   assign io_bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed bench for cla_serial_add_ctrl (WIDTH=16): expected results go into a
// scoreboard queue; a negedge monitor pops and compares on each result handshake.
module tb_cla_serial_add_ctrl;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned NIB   = WIDTH / 4;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   cla_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   cla_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: result handshake visible at negedge, completes at the next posedge
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sum",  32'(bus.sum),  32'(e.sum));
            chk("cout", 32'(bus.cout), 32'(e.cout));
            chk("ovf",  32'(bus.ovf),  32'(e.ovf));
         end
      end
   end

   // Issue one op from IDLE, check latency/in_ready, hold off out_ready for
   // `hold` cycles (optionally presenting a decoy op), then complete the handshake.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                        input int hold, input logic decoy);
      int lat;
      sb_q.push_back('{sum: es, cout: ec, ovf: eo});
      bus.in_valid = 1'b1;
      bus.a = a; bus.b = b; bus.cin = cin; bus.op_sub = sub;
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a = ~a; bus.b = 16'h5A5A; bus.cin = ~cin; bus.op_sub = ~sub;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         chk("in_ready_run", 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(NIB));
      if (decoy) begin
         bus.in_valid = 1'b1;
         bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.op_sub = 1'b0;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         chk("hold_sum", 32'(bus.sum), 32'(es));
         chk("hold_cout", 32'(bus.cout), 32'(ec));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
      chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op_sub = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_cout", 32'(bus.cout), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);

      // out_ready while idle must do nothing
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

      do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
      do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
      do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 0, 1'b0);

      // Backpressure with a decoy op presented while DONE
      do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 3, 1'b1);
      do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0, 1'b0);

      // Reset after two nibbles of an in-flight op
      bus.in_valid = 1'b1;
      bus.a = 16'hABCD; bus.b = 16'h1111; bus.cin = 1'b0; bus.op_sub = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_sum", 32'(bus.sum), 32'd0);
      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 1'b0);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
